carry_chain_add_arbiter: RTL and testbench

//  Shares one W-bit carry-chain adder (carry_chain_sum_old) among NREQ requesters.

---
 rtl/carry_chain_pkg.sv | 26 ++
 rtl/carry_chain_sum_old.sv | 26 ++
 rtl/cca_rr_arbiter.sv | 35 +++
 rtl/carry_chain_add_arbiter.sv | 146 ++++++++++++++
 tb/tb_carry_chain_add_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/carry_chain_pkg.sv
// Shared types and constants for the carry-chain adder arbiter.
// No logic, no latency.
// No flow control.
package carry_chain_pkg;

    localparam int DEF_W    = 64;
    localparam int DEF_NREQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } cca_state_t;

    // Constant-evaluable ceil(log2(v)), for v >= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/carry_chain_sum_old.sv
// W-bit carry-chain adder built from 8-bit slices with rippled carry.
// Latency: combinational.
// Backpressure: none.
module carry_chain_sum_old #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int NS = W / 8;

    logic [NS:0] c;

    assign c[0] = cin;

    for (genvar s = 0; s < NS; s++) begin : g_slice
        assign {c[s+1], sum[s*8 +: 8]} = {1'b0, a[s*8 +: 8]} + {1'b0, b[s*8 +: 8]} + {8'b0, c[s]};
    end

    assign cout = c[NS];

endmodule

// File: rtl/cca_rr_arbiter.sv
// Cyclic priority pick: first requester at or after rr_ptr with valid set.
// Latency: combinational.
// Backpressure: none; grant is advisory until the caller locks it.
module cca_rr_arbiter
    import carry_chain_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  grant_id,
    output logic            any_vld
);

    logic [IDW:0] idx;

    // Walk from the furthest offset down so the nearest valid requester wins.
    always_comb begin
        grant_id = '0;
        any_vld  = 1'b0;
        idx      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (req_valid[idx[IDW-1:0]]) begin
                grant_id = idx[IDW-1:0];
                any_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/carry_chain_add_arbiter.sv
// Round-robin share of one carry-chain adder; grant locked per multi-beat transaction.
// Latency: one bubble for the grant, then 1 cycle beat accept -> rsp_valid, 1 beat/cycle.
// Backpressure: owner's req_ready = !rsp_valid | rsp_ready; optional rsp_ovf via CCA_OVF_FLAG_EN.
module carry_chain_add_arbiter
    import carry_chain_pkg::*;
#(
    parameter  int W    = DEF_W,
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_last,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_last
`ifdef CCA_OVF_FLAG_EN
    ,
    output logic              rsp_ovf
`endif
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    cca_state_t     state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_ptr;
    logic           carry_q;
    logic           first_q;

    logic [IDW-1:0] grant_id;
    logic           any_vld;

    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   sum_w;
    logic           cin_w;
    logic           cout_w;
    logic           beat_last;
    logic           lock_rdy;
    logic           beat_acc;

    cca_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_id  (grant_id),
        .any_vld   (any_vld)
    );

    assign op_a      = req_a[int'(owner) * W +: W];
    assign op_b      = req_b[int'(owner) * W +: W];
    assign beat_last = req_last[owner];
    // Carry-in from the requester only opens a transaction; later beats chain.
    assign cin_w     = first_q ? req_cin[owner] : carry_q;

    carry_chain_sum_old #(
        .W (W)
    ) u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (cin_w),
        .sum  (sum_w),
        .cout (cout_w)
    );

    assign lock_rdy = !rsp_valid || rsp_ready;
    assign beat_acc = (state == LOCK) && req_valid[owner] && lock_rdy;

    always_comb begin
        req_ready = '0;
        if (state == LOCK) begin
            req_ready[owner] = lock_rdy;
        end
    end

`ifdef CCA_OVF_FLAG_EN
    logic ovf_w;
    // Signed overflow is only meaningful on the most significant word.
    assign ovf_w = beat_last && (op_a[W-1] == op_b[W-1]) && (sum_w[W-1] != op_a[W-1]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            carry_q   <= 1'b0;
            first_q   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            rsp_last  <= 1'b0;
`ifdef CCA_OVF_FLAG_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        owner <= grant_id;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (beat_acc) begin
                        if (beat_last) begin
                            carry_q <= 1'b0;
                            first_q <= 1'b1;
                            rr_ptr  <= (owner == LAST_ID) ? '0 : owner + 1'b1;
                            state   <= IDLE;
                        end else begin
                            carry_q <= cout_w;
                            first_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (beat_acc) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= sum_w;
                rsp_cout  <= cout_w;
                rsp_id    <= owner;
                rsp_last  <= beat_last;
`ifdef CCA_OVF_FLAG_EN
                rsp_ovf   <= ovf_w;
`endif
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_carry_chain_add_arbiter.sv
// Directed bench for carry_chain_add_arbiter with an expected-response scoreboard.
// Exercises CCA_OVF_FLAG_EN checks when that macro is defined.
module tb_carry_chain_add_arbiter;

    localparam int W    = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef CCA_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0]   sum;
        logic           cout;
        logic [IDW-1:0] id;
        logic           last;
        logic           ovf;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_last;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_last;
    logic              ovf_obs;
`ifdef CCA_OVF_FLAG_EN
    logic              rsp_ovf;
    assign ovf_obs = rsp_ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    carry_chain_add_arbiter #(
        .W    (W),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last)
`ifdef CCA_OVF_FLAG_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    rsp_t exp_q[$];
    rsp_t got_q[$];
    logic m_first = 1'b1;
    logic m_carry = 1'b0;
    logic [W-1:0] ba [0:7];
    logic [W-1:0] bb [0:7];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t cur_rsp();
        rsp_t r;
        r.sum  = rsp_sum;
        r.cout = rsp_cout;
        r.id   = rsp_id;
        r.last = rsp_last;
        r.ovf  = ovf_obs;
        return r;
    endfunction

    // One clock: score any consumed response, predict any accepted beat.
    task automatic cyc(output logic [NREQ-1:0] acc);
        rsp_t         e;
        rsp_t         g;
        logic [W:0]   full;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        @(negedge clk);
        acc = '0;
        if (rsp_valid && rsp_ready) begin
            g = cur_rsp();
            got_q.push_back(g);
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 128'(g), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rsp", 128'(g), 128'(e));
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                acc[k] = 1'b1;
                a      = req_a[k*W +: W];
                b      = req_b[k*W +: W];
                ci     = m_first ? req_cin[k] : m_carry;
                full   = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
                e.sum  = full[W-1:0];
                e.cout = full[W];
                e.id   = IDW'(k);
                e.last = req_last[k];
                e.ovf  = OVF_EN && req_last[k] && (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
                exp_q.push_back(e);
                m_carry = req_last[k] ? 1'b0 : full[W];
                m_first = req_last[k];
            end
        end
        chk("ready_onehot", 128'($onehot0(req_ready)), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int k, input int i, input int n);
        req_a[k*W +: W] = ba[i];
        req_b[k*W +: W] = bb[i];
        req_last[k]     = (i == n - 1);
    endtask

    task automatic stall5();
        logic [NREQ-1:0] acc;
        rsp_t            snap;
        rsp_ready = 1'b0;
        snap = cur_rsp();
        repeat (5) begin
            cyc(acc);
            chk("stall_req_ready", 128'(req_ready), 128'(0));
            chk("stall_valid", 128'(rsp_valid), 128'(1));
            chk("stall_hold", 128'(cur_rsp()), 128'(snap));
        end
        rsp_ready = 1'b1;
    endtask

    task automatic run_txn(input int k, input int n, input logic cin, input int stall_at, output int lat);
        int              done;
        int              ncyc;
        logic [NREQ-1:0] acc;
        done = 0;
        ncyc = 0;
        lat  = -1;
        req_cin[k] = cin;
        set_beat(k, 0, n);
        req_valid[k] = 1'b1;
        while (done < n && ncyc < 200) begin
            cyc(acc);
            ncyc++;
            if (lat < 0 && rsp_valid) lat = ncyc;
            if (acc[k]) begin
                done++;
                if (done < n) set_beat(k, done, n);
                else req_valid[k] = 1'b0;
                if (done == stall_at) stall5();
            end
        end
        req_valid[k] = 1'b0;
        chk("txn_beats", 128'(done), 128'(n));
    endtask

    task automatic drain();
        logic [NREQ-1:0] acc;
        int              c;
        c = 0;
        while ((exp_q.size() != 0 || rsp_valid) && c < 50) begin
            cyc(acc);
            c++;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] want;
        int              lat;
        int              nc;
        int              accepts;
        int              exp_id;
        logic            seen0;
        logic            seen3;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_last  = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_valid", 128'(rsp_valid), 128'(0));
        chk("rst_ready", 128'(req_ready), 128'(0));
        chk("rst_sum", 128'(rsp_sum), 128'(0));
        chk("rst_misc", 128'({rsp_cout, rsp_id, rsp_last, ovf_obs}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) cyc(acc);
        chk("idle_ready", 128'(req_ready), 128'(0));

        // Single beat carrying out of the top bit.
        got_q.delete();
        ba[0] = '1;
        bb[0] = 64'd1;
        run_txn(1, 1, 1'b0, -1, lat);
        chk("t2_latency", 128'(lat), 128'(2));
        drain();
        chk("t2_count", 128'(got_q.size()), 128'(1));
        if (got_q.size() == 1) begin
            chk("t2_sum", 128'(got_q[0].sum), 128'(0));
            chk("t2_cout_id_last", 128'({got_q[0].cout, got_q[0].id, got_q[0].last}), 128'({1'b1, 2'd1, 1'b1}));
        end

        // Two-beat chained add.
        got_q.delete();
        ba[0] = '1;
        bb[0] = 64'd0;
        ba[1] = 64'd5;
        bb[1] = 64'd7;
        run_txn(2, 2, 1'b1, -1, lat);
        drain();
        chk("t3_count", 128'(got_q.size()), 128'(2));
        if (got_q.size() == 2) begin
            chk("t3_b0", 128'({got_q[0].sum, got_q[0].cout, got_q[0].id, got_q[0].last}),
                128'({64'd0, 1'b1, 2'd2, 1'b0}));
            chk("t3_b1", 128'({got_q[1].sum, got_q[1].cout, got_q[1].id, got_q[1].last}),
                128'({64'hD, 1'b0, 2'd2, 1'b1}));
        end

        // Reset in the middle of a locked transaction from requester 3.
        for (int i = 0; i < 3; i++) begin
            ba[i] = {$urandom, $urandom};
            bb[i] = {$urandom, $urandom};
        end
        req_cin[3] = 1'b0;
        set_beat(3, 0, 3);
        req_valid[3] = 1'b1;
        nc  = 0;
        acc = '0;
        while (!acc[3] && nc < 20) begin
            cyc(acc);
            nc++;
        end
        chk("t1_first_beat", 128'(acc[3]), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t1_rst_valid", 128'(rsp_valid), 128'(0));
        chk("t1_rst_ready", 128'(req_ready), 128'(0));
        chk("t1_rst_outs", 128'({rsp_sum, rsp_cout, rsp_id, rsp_last, ovf_obs}), 128'(0));
        exp_q.delete();
        m_first = 1'b1;
        m_carry = 1'b0;
        req_a[0*W +: W] = 64'd100;
        req_b[0*W +: W] = 64'd23;
        req_a[3*W +: W] = 64'd9;
        req_b[3*W +: W] = 64'd1;
        req_cin   = 4'b0000;
        req_last  = 4'b1001;
        req_valid = 4'b1001;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen0 = 1'b0;
        seen3 = 1'b0;
        nc    = 0;
        while (!(seen0 && seen3) && nc < 40) begin
            cyc(acc);
            nc++;
            if (acc != 0 && !seen0 && !seen3) chk("t1_grant_after_rst", 128'(acc), 128'(4'b0001));
            if (acc[0]) begin seen0 = 1'b1; req_valid[0] = 1'b0; end
            if (acc[3]) begin seen3 = 1'b1; req_valid[3] = 1'b0; end
        end
        chk("t1_both_served", 128'({seen0, seen3}), 128'(2'b11));
        drain();

        // Output stall in the middle of a four-beat transaction.
        for (int i = 0; i < 4; i++) begin
            ba[i] = {$urandom, $urandom};
            bb[i] = {$urandom, $urandom};
        end
        ba[0] = '1;
        bb[0] = '1;
        got_q.delete();
        run_txn(3, 4, 1'b1, 2, lat);
        drain();
        chk("t5_count", 128'(got_q.size()), 128'(4));

        // All four requesters always busy: strict rotation.
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*W +: W] = {$urandom, $urandom};
            req_b[k*W +: W] = {$urandom, $urandom};
            req_cin[k]      = 1'($urandom_range(0, 1));
        end
        req_last  = '1;
        req_valid = '1;
        accepts   = 0;
        exp_id    = 0;
        nc        = 0;
        while (accepts < 400 && nc < 3000) begin
            cyc(acc);
            nc++;
            if (acc != 0) begin
                want = 4'b0001 << exp_id;
                chk("t4_order", 128'(acc), 128'(want));
                for (int k = 0; k < NREQ; k++) begin
                    if (acc[k]) begin
                        req_a[k*W +: W] = {$urandom, $urandom};
                        req_b[k*W +: W] = {$urandom, $urandom};
                        req_cin[k]      = 1'($urandom_range(0, 1));
                    end
                end
                exp_id = (exp_id + 1) % NREQ;
                accepts++;
            end
        end
        req_valid = '0;
        chk("t4_accepts", 128'(accepts), 128'(400));
        drain();

`ifdef CCA_OVF_FLAG_EN
        got_q.delete();
        ba[0] = 64'h7FFF_FFFF_FFFF_FFFF;
        bb[0] = 64'd1;
        run_txn(0, 1, 1'b0, -1, lat);
        drain();
        if (got_q.size() == 1) chk("t6_ovf_last", 128'({got_q[0].sum, got_q[0].ovf}), 128'({64'h8000_0000_0000_0000, 1'b1}));
        else chk("t6_count_a", 128'(got_q.size()), 128'(1));
        got_q.delete();
        ba[1] = 64'd0;
        bb[1] = 64'd0;
        run_txn(0, 2, 1'b0, -1, lat);
        drain();
        if (got_q.size() == 2) chk("t6_ovf_nonlast", 128'({got_q[0].ovf, got_q[1].ovf}), 128'(2'b00));
        else chk("t6_count_b", 128'(got_q.size()), 128'(2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
